// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Collects results from NUM_SOURCES functional units, each buffered in a
//   private in-order FIFO, and grants one result per cycle round-robin onto a
//   registered two-port register-file writeback bus. While the register file
//   stalls, the bus holds its contents and the FIFOs keep absorbing pushes.
module writeback_arbiter #(
   parameter int NUM_SOURCES     = 3,
   parameter int FIFO_DEPTH      = 4,
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 6,
   parameter int UNIT_CODE_WIDTH = 3,
   // Unit code per source, source 0 in the LSBs: src0=1, src1=2, src2=0
   parameter logic [NUM_SOURCES*UNIT_CODE_WIDTH-1:0] UNIT_CODES = 9'b000_010_001
) (
   input  logic                              clock_i,
   input  logic                              reset_i,
   input  logic [NUM_SOURCES-1:0]            srcValid_i,
   output logic [NUM_SOURCES-1:0]            srcReady_o,
   input  logic [NUM_SOURCES-1:0]            srcWbEn1_i,
   input  logic [NUM_SOURCES-1:0]            srcWbEn2_i,
   input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] srcAddr1_i,
   input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] srcAddr2_i,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0] srcVal1_i,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0] srcVal2_i,
   input  logic                              wbStall_i,
   output logic                              wbValid_o,
   output logic [UNIT_CODE_WIDTH-1:0]        functionalUnitCode_o,
   output logic                              reg1WritebackEnable_o,
   output logic                              reg2WritebackEnable_o,
   output logic [ADDR_WIDTH-1:0]             reg1WritebackAddress_o,
   output logic [ADDR_WIDTH-1:0]             reg2WritebackAddress_o,
   output logic [DATA_WIDTH-1:0]             reg1WritebackVal_o,
   output logic [DATA_WIDTH-1:0]             reg2WritebackVal_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(NUM_SOURCES);

   localparam logic [PW-1:0] PTR_ONE   = PW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] RR_RESET  = SW'(NUM_SOURCES - 1);

   typedef struct packed {
      logic                  en1;
      logic                  en2;
      logic [ADDR_WIDTH-1:0] addr1;
      logic [ADDR_WIDTH-1:0] addr2;
      logic [DATA_WIDTH-1:0] val1;
      logic [DATA_WIDTH-1:0] val2;
   } entry_t;

   logic [NUM_SOURCES-1:0] full_s;
   logic [NUM_SOURCES-1:0] nonempty_s;
   entry_t                 head_s [NUM_SOURCES];
   entry_t                 grant_entry_s;
   logic                   grant_found_s;
   logic [SW-1:0]          grant_idx_s;
   logic [SW-1:0]          rr_ptr_r;

   assign srcReady_o = ~full_s;

   for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
      entry_t        mem_r [FIFO_DEPTH];
      entry_t        in_entry_s;
      logic [CW-1:0] count_r;
      logic [PW-1:0] wr_ptr_r;
      logic [PW-1:0] rd_ptr_r;
      logic          push_s;
      logic          pop_s;

      assign in_entry_s = {srcWbEn1_i[g], srcWbEn2_i[g],
                           srcAddr1_i[g*ADDR_WIDTH +: ADDR_WIDTH],
                           srcAddr2_i[g*ADDR_WIDTH +: ADDR_WIDTH],
                           srcVal1_i[g*DATA_WIDTH +: DATA_WIDTH],
                           srcVal2_i[g*DATA_WIDTH +: DATA_WIDTH]};
      assign full_s[g]     = (count_r == CNT_FULL);
      assign nonempty_s[g] = (count_r != CNT_ZERO);
      // Entries with no write enable complete the handshake but are dropped
      assign push_s = srcValid_i[g] & ~full_s[g] & (srcWbEn1_i[g] | srcWbEn2_i[g]);
      assign pop_s  = grant_found_s & ~wbStall_i & (grant_idx_s == SW'(g));
      assign head_s[g] = mem_r[rd_ptr_r];

      // Occupancy and read/write pointers of this source FIFO
      always_ff @(posedge clock_i or posedge reset_i) begin
         if (reset_i) begin
            count_r  <= CNT_ZERO;
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + CNT_ONE;
               2'b01:   count_r <= count_r - CNT_ONE;
               default: count_r <= count_r;
            endcase
         end
      end

      // Entry storage; contents need no reset since occupancy gates every read
      always_ff @(posedge clock_i) begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
         end
      end
   end

   // Round-robin search starting one past the last granted source
   always_comb begin
      int            cand_v;
      logic [SW-1:0] sel_v;
      grant_found_s = 1'b0;
      grant_idx_s   = rr_ptr_r;
      cand_v        = 0;
      sel_v         = {SW{1'b0}};
      for (int i = 1; i <= NUM_SOURCES; i++) begin
         cand_v = (int'(rr_ptr_r) + i) % NUM_SOURCES;
         sel_v  = cand_v[SW-1:0];
         if (!grant_found_s && nonempty_s[sel_v]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = sel_v;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign grant_entry_s = head_s[grant_idx_s];

   // Writeback bus registers and grant pointer; everything holds during a stall
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         rr_ptr_r               <= RR_RESET;
         wbValid_o              <= 1'b0;
         functionalUnitCode_o   <= {UNIT_CODE_WIDTH{1'b0}};
         reg1WritebackEnable_o  <= 1'b0;
         reg2WritebackEnable_o  <= 1'b0;
         reg1WritebackAddress_o <= {ADDR_WIDTH{1'b0}};
         reg2WritebackAddress_o <= {ADDR_WIDTH{1'b0}};
         reg1WritebackVal_o     <= {DATA_WIDTH{1'b0}};
         reg2WritebackVal_o     <= {DATA_WIDTH{1'b0}};
      end else if (!wbStall_i) begin
         if (grant_found_s) begin
            rr_ptr_r               <= grant_idx_s;
            wbValid_o              <= 1'b1;
            functionalUnitCode_o   <= UNIT_CODES[int'(grant_idx_s)*UNIT_CODE_WIDTH +: UNIT_CODE_WIDTH];
            reg1WritebackEnable_o  <= grant_entry_s.en1;
            reg2WritebackEnable_o  <= grant_entry_s.en2;
            reg1WritebackAddress_o <= grant_entry_s.addr1;
            reg2WritebackAddress_o <= grant_entry_s.addr2;
            reg1WritebackVal_o     <= grant_entry_s.val1;
            reg2WritebackVal_o     <= grant_entry_s.val2;
         end else begin
            wbValid_o              <= 1'b0;
            reg1WritebackEnable_o  <= 1'b0;
            reg2WritebackEnable_o  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, latency, round-robin order,
// backpressure, stall hold and discard of enable-less results.
module tb_writeback_arbiter;

   logic         clock_i = 1'b0;
   logic         reset_i = 1'b0;
   logic [2:0]   srcValid_i = 3'b000;
   logic [2:0]   srcReady_o;
   logic [2:0]   srcWbEn1_i = 3'b000;
   logic [2:0]   srcWbEn2_i = 3'b000;
   logic [17:0]  srcAddr1_i = 18'd0;
   logic [17:0]  srcAddr2_i = 18'd0;
   logic [191:0] srcVal1_i = 192'd0;
   logic [191:0] srcVal2_i = 192'd0;
   logic         wbStall_i = 1'b0;
   logic         wbValid_o;
   logic [2:0]   functionalUnitCode_o;
   logic         reg1WritebackEnable_o;
   logic         reg2WritebackEnable_o;
   logic [5:0]   reg1WritebackAddress_o;
   logic [5:0]   reg2WritebackAddress_o;
   logic [63:0]  reg1WritebackVal_o;
   logic [63:0]  reg2WritebackVal_o;

   int total = 0;
   int bad   = 0;

   writeback_arbiter dut (
      .clock_i               (clock_i),
      .reset_i               (reset_i),
      .srcValid_i            (srcValid_i),
      .srcReady_o            (srcReady_o),
      .srcWbEn1_i            (srcWbEn1_i),
      .srcWbEn2_i            (srcWbEn2_i),
      .srcAddr1_i            (srcAddr1_i),
      .srcAddr2_i            (srcAddr2_i),
      .srcVal1_i             (srcVal1_i),
      .srcVal2_i             (srcVal2_i),
      .wbStall_i             (wbStall_i),
      .wbValid_o             (wbValid_o),
      .functionalUnitCode_o  (functionalUnitCode_o),
      .reg1WritebackEnable_o (reg1WritebackEnable_o),
      .reg2WritebackEnable_o (reg2WritebackEnable_o),
      .reg1WritebackAddress_o(reg1WritebackAddress_o),
      .reg2WritebackAddress_o(reg2WritebackAddress_o),
      .reg1WritebackVal_o    (reg1WritebackVal_o),
      .reg2WritebackVal_o    (reg2WritebackVal_o)
   );

   // Free-running clock, period 10
   always #5 clock_i = ~clock_i;

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int s, input logic v, input logic e1, input logic e2,
                          input logic [5:0] a1, input logic [5:0] a2,
                          input logic [63:0] v1, input logic [63:0] v2);
      srcValid_i[s]          = v;
      srcWbEn1_i[s]          = e1;
      srcWbEn2_i[s]          = e2;
      srcAddr1_i[s*6 +: 6]   = a1;
      srcAddr2_i[s*6 +: 6]   = a2;
      srcVal1_i[s*64 +: 64]  = v1;
      srcVal2_i[s*64 +: 64]  = v2;
   endtask

   logic [5:0]  rr_addr [6];
   logic [2:0]  rr_unit [6];
   logic [63:0] rr_val  [6];

   initial begin
      rr_addr = '{6'd10, 6'd12, 6'd14, 6'd11, 6'd13, 6'd15};
      rr_unit = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
      rr_val  = '{64'h100, 64'h101, 64'h102, 64'h110, 64'h111, 64'h112};

      // ---- initial reset ----
      #2 reset_i = 1'b1;
      #1;
      chk("rst_valid", wbValid_o, 1'b0);
      chk("rst_addr1", reg1WritebackAddress_o, 6'd0);
      tick();
      tick();
      reset_i = 1'b0;
      chk("rst_ready", srcReady_o, 3'b111);

      // ---- 1: reset in the middle of traffic on src1 ----
      set_src(1, 1'b1, 1'b1, 1'b0, 6'd1, 6'd0, 64'hA1, 64'h0);
      tick();
      set_src(1, 1'b1, 1'b1, 1'b0, 6'd2, 6'd0, 64'hA2, 64'h0);
      tick();
      chk("t1_first_valid", wbValid_o, 1'b1);
      chk("t1_first_addr", reg1WritebackAddress_o, 6'd1);
      chk("t1_first_unit", functionalUnitCode_o, 3'd2);
      set_src(1, 1'b1, 1'b1, 1'b0, 6'd3, 6'd0, 64'hA3, 64'h0);
      tick();
      set_src(1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
      chk("t1_second_addr", reg1WritebackAddress_o, 6'd2);
      #2 reset_i = 1'b1;
      #1;
      chk("t1_async_valid", wbValid_o, 1'b0);
      chk("t1_async_en1", reg1WritebackEnable_o, 1'b0);
      chk("t1_async_addr1", reg1WritebackAddress_o, 6'd0);
      chk("t1_async_val1", reg1WritebackVal_o, 64'h0);
      chk("t1_async_unit", functionalUnitCode_o, 3'd0);
      tick();
      tick();
      reset_i = 1'b0;
      chk("t1_ready_after", srcReady_o, 3'b111);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_no_stale", wbValid_o, 1'b0);
      end

      // ---- 2: latency of a single push on src0 ----
      set_src(0, 1'b1, 1'b1, 1'b0, 6'd5, 6'd0, 64'hDEAD, 64'h0);
      tick();
      set_src(0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
      chk("t2_not_yet", wbValid_o, 1'b0);
      tick();
      chk("t2_valid", wbValid_o, 1'b1);
      chk("t2_addr1", reg1WritebackAddress_o, 6'd5);
      chk("t2_val1", reg1WritebackVal_o, 64'hDEAD);
      chk("t2_unit", functionalUnitCode_o, 3'd1);
      chk("t2_en1", reg1WritebackEnable_o, 1'b1);
      chk("t2_en2", reg2WritebackEnable_o, 1'b0);
      tick();
      chk("t2_idle_valid", wbValid_o, 1'b0);
      chk("t2_idle_en1", reg1WritebackEnable_o, 1'b0);
      chk("t2_idle_addr_hold", reg1WritebackAddress_o, 6'd5);

      // ---- 3: round-robin with two entries per source ----
      #1 reset_i = 1'b1;
      #1 reset_i = 1'b0;
      wbStall_i = 1'b1;
      for (int s = 0; s < 3; s++)
         set_src(s, 1'b1, 1'b1, 1'b0, 6'(10 + 2*s), 6'd0, 64'(256 + s), 64'h0);
      tick();
      for (int s = 0; s < 3; s++)
         set_src(s, 1'b1, 1'b1, 1'b0, 6'(11 + 2*s), 6'd0, 64'(272 + s), 64'h0);
      tick();
      for (int s = 0; s < 3; s++)
         set_src(s, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
      chk("t3_stalled_valid", wbValid_o, 1'b0);
      wbStall_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t3_valid", wbValid_o, 1'b1);
         chk("t3_unit", functionalUnitCode_o, rr_unit[k]);
         chk("t3_addr1", reg1WritebackAddress_o, rr_addr[k]);
         chk("t3_val1", reg1WritebackVal_o, rr_val[k]);
      end
      tick();
      chk("t3_drained", wbValid_o, 1'b0);

      // ---- 4: fill src2 under stall, then drain ----
      wbStall_i = 1'b1;
      set_src(2, 1'b1, 1'b1, 1'b0, 6'd20, 6'd0, 64'h400, 64'h0);
      tick();
      chk("t4_ready_1", srcReady_o[2], 1'b1);
      set_src(2, 1'b1, 1'b1, 1'b0, 6'd21, 6'd0, 64'h401, 64'h0);
      tick();
      set_src(2, 1'b1, 1'b1, 1'b0, 6'd22, 6'd0, 64'h402, 64'h0);
      tick();
      chk("t4_ready_3", srcReady_o[2], 1'b1);
      set_src(2, 1'b1, 1'b1, 1'b0, 6'd23, 6'd0, 64'h403, 64'h0);
      tick();
      chk("t4_full", srcReady_o[2], 1'b0);
      chk("t4_other_ready", srcReady_o[1:0], 2'b11);
      set_src(2, 1'b1, 1'b1, 1'b0, 6'd24, 6'd0, 64'h404, 64'h0);
      tick();
      chk("t4_still_full", srcReady_o[2], 1'b0);
      chk("t4_stall_valid", wbValid_o, 1'b0);
      wbStall_i = 1'b0;
      tick();
      chk("t4_pop0_addr", reg1WritebackAddress_o, 6'd20);
      chk("t4_pop0_unit", functionalUnitCode_o, 3'd0);
      chk("t4_ready_back", srcReady_o[2], 1'b1);
      tick();
      set_src(2, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
      chk("t4_pop1_addr", reg1WritebackAddress_o, 6'd21);
      tick();
      chk("t4_pop2_addr", reg1WritebackAddress_o, 6'd22);
      tick();
      chk("t4_pop3_addr", reg1WritebackAddress_o, 6'd23);
      tick();
      chk("t4_pop4_addr", reg1WritebackAddress_o, 6'd24);
      chk("t4_pop4_val", reg1WritebackVal_o, 64'h404);
      tick();
      chk("t4_drained", wbValid_o, 1'b0);

      // ---- 5: stall holds bus and pointer ----
      set_src(1, 1'b1, 1'b1, 1'b1, 6'd30, 6'd31, 64'h300, 64'h301);
      set_src(2, 1'b1, 1'b1, 1'b0, 6'd40, 6'd0, 64'h4000, 64'h0);
      tick();
      set_src(1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
      set_src(2, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
      tick();
      chk("t5_src1_addr1", reg1WritebackAddress_o, 6'd30);
      chk("t5_src1_unit", functionalUnitCode_o, 3'd2);
      chk("t5_src1_en2", reg2WritebackEnable_o, 1'b1);
      chk("t5_src1_addr2", reg2WritebackAddress_o, 6'd31);
      chk("t5_src1_val2", reg2WritebackVal_o, 64'h301);
      wbStall_i = 1'b1;
      set_src(0, 1'b1, 1'b1, 1'b0, 6'd50, 6'd0, 64'h500, 64'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         set_src(0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
         chk("t5_hold_valid", wbValid_o, 1'b1);
         chk("t5_hold_addr1", reg1WritebackAddress_o, 6'd30);
         chk("t5_hold_val1", reg1WritebackVal_o, 64'h300);
         chk("t5_hold_unit", functionalUnitCode_o, 3'd2);
      end
      wbStall_i = 1'b0;
      tick();
      chk("t5_next_addr", reg1WritebackAddress_o, 6'd40);
      chk("t5_next_unit", functionalUnitCode_o, 3'd0);
      chk("t5_next_en2", reg2WritebackEnable_o, 1'b0);
      tick();
      chk("t5_then_addr", reg1WritebackAddress_o, 6'd50);
      chk("t5_then_unit", functionalUnitCode_o, 3'd1);
      tick();
      chk("t5_drained", wbValid_o, 1'b0);

      // ---- 6: enable-less entry is discarded ----
      set_src(0, 1'b1, 1'b0, 1'b0, 6'd60, 6'd61, 64'h600, 64'h601);
      chk("t6_ready", srcReady_o[0], 1'b1);
      tick();
      set_src(0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 64'h0, 64'h0);
      chk("t6_ready_after", srcReady_o[0], 1'b1);
      tick();
      chk("t6_valid_a", wbValid_o, 1'b0);
      tick();
      chk("t6_valid_b", wbValid_o, 1'b0);
      chk("t6_addr_hold", reg1WritebackAddress_o, 6'd50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
